// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window MAC.
package conv_pkg;

    // Controller phases: wait for a window, multiply-accumulate it, publish the result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } conv_state_e;

    // Accumulator width that can hold N full-scale signed products without overflow.
    function automatic int acc_width(input int img_w, input int krn_w, input int n);
        return img_w + krn_w + 1 + $clog2(n);
    endfunction

    // Index/counter width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_sat_relu.sv
// Converts a signed accumulator into an unsigned output pixel (clamp low at 0, saturate high).
module conv_sat_relu #(
    parameter int ACC_WIDTH = 21,
    parameter int OUT_WIDTH = 8,
    parameter int RELU_EN   = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic        [OUT_WIDTH-1:0] pix_o
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    // Clamp negative sums to zero and large sums to the output full scale.
    always_comb begin
        pix_o = '0;
        if (acc_i[ACC_WIDTH-1]) begin
            // The output is unsigned, so both ReLU modes floor negatives at zero.
            if (RELU_EN != 0) begin
                pix_o = '0;
            end else begin
                pix_o = '0;
            end
        end else if (acc_i > MAX_V) begin
            pix_o = {OUT_WIDTH{1'b1}};
        end else begin
            pix_o = acc_i[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential convolution window MAC: one product per cycle over a captured
// KERNEL_SIZE x KERNEL_SIZE window, followed by ReLU/saturation of the sum.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int IMAGE_PIXEL_WIDTH  = 8,
    parameter int KERNEL_PIXEL_WIDTH = 8,
    parameter int KERNEL_SIZE        = 3,
    parameter int OUT_WIDTH          = 8,
    parameter int NUM_WINDOWS        = 576,
    parameter int RELU_EN            = 1
) (
    input  logic                                                             clock,
    input  logic                                                             rst_n,
    input  logic                                                             win_valid,
    output logic                                                             win_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0][IMAGE_PIXEL_WIDTH-1:0]       IMD,
    input  logic                                                             wgt_load,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0][KERNEL_PIXEL_WIDTH-1:0]      WC1D,
    output logic [OUT_WIDTH-1:0]                                             pix_out,
    output logic                                                             pix_valid,
    output logic                                                             map_done,
    output logic                                                             overrun
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW = acc_width(IMAGE_PIXEL_WIDTH, KERNEL_PIXEL_WIDTH, N);
    localparam int PW = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH + 1;
    localparam int IW = idx_width(N);
    localparam int CW = idx_width(NUM_WINDOWS);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WINDOWS - 1);

    conv_state_e                                    state_q, state_d;
    logic [N-1:0][IMAGE_PIXEL_WIDTH-1:0]            win_q, win_d;
    logic [N-1:0][KERNEL_PIXEL_WIDTH-1:0]           wgt_q, wgt_d;
    logic signed [AW-1:0]                           acc_q, acc_d;
    logic [IW-1:0]                                  idx_q, idx_d;
    logic [CW-1:0]                                  cnt_q, cnt_d;
    logic                                           win_ready_q, win_ready_d;
    logic                                           pix_valid_q, pix_valid_d;
    logic [OUT_WIDTH-1:0]                           pix_out_q, pix_out_d;
    logic                                           map_done_q, map_done_d;
    logic                                           overrun_q, overrun_d;

    logic signed [PW-1:0]                           pix_ext_s;
    logic signed [PW-1:0]                           wgt_ext_s;
    logic signed [PW-1:0]                           prod_s;
    logic signed [AW-1:0]                           prod_ext_s;
    logic [OUT_WIDTH-1:0]                           sat_s;

    // Final post-processing of the completed sum (acc_q is stable throughout EMIT).
    conv_sat_relu #(
        .ACC_WIDTH (AW),
        .OUT_WIDTH (OUT_WIDTH),
        .RELU_EN   (RELU_EN)
    ) u_sat_relu (
        .acc_i (acc_q),
        .pix_o (sat_s)
    );

    // Current element product: pixel zero-extended, weight sign-extended, exact in PW bits.
    always_comb begin
        pix_ext_s  = $signed({{(PW-IMAGE_PIXEL_WIDTH){1'b0}}, win_q[idx_q]});
        wgt_ext_s  = $signed({{(PW-KERNEL_PIXEL_WIDTH){wgt_q[idx_q][KERNEL_PIXEL_WIDTH-1]}}, wgt_q[idx_q]});
        prod_s     = pix_ext_s * wgt_ext_s;
        prod_ext_s = $signed({{(AW-PW){prod_s[PW-1]}}, prod_s});
    end

    // Next-state and next-output logic for the IDLE/ACCUM/EMIT controller.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pix_valid_d = 1'b0;
        pix_out_d   = pix_out_q;
        map_done_d  = map_done_q;
        overrun_d   = overrun_q;

        // Weights are captured in every state; an in-flight window sees them from the next product.
        if (wgt_load) begin
            wgt_d = WC1D;
        end else begin
            wgt_d = wgt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    win_d   = IMD;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + prod_ext_s;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_ACCUM;
                end
                if (win_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_EMIT: begin
                pix_valid_d = 1'b1;
                pix_out_d   = sat_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    map_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                end
                if (win_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        win_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset clears any partial sum and the loaded weights.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            wgt_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            win_ready_q <= 1'b1;
            pix_valid_q <= 1'b0;
            pix_out_q   <= '0;
            map_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            wgt_q       <= wgt_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            win_ready_q <= win_ready_d;
            pix_valid_q <= pix_valid_d;
            pix_out_q   <= pix_out_d;
            map_done_q  <= map_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign win_ready = win_ready_q;
    assign pix_valid = pix_valid_q;
    assign pix_out   = pix_out_q;
    assign map_done  = map_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed + randomized bench for conv_window_mac (3x3 kernel, 8-bit output, 4 windows per map).
module tb_conv_window_mac;

    typedef logic [8:0][7:0] vec9_t;

    logic        clock;
    logic        rst_n;
    logic        win_valid;
    logic        win_ready;
    vec9_t       IMD;
    logic        wgt_load;
    vec9_t       WC1D;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        map_done;
    logic        overrun;

    int    chk_n;
    int    err_n;
    int    n_win;
    logic  exp_ovr;
    vec9_t cur_w;

    conv_window_mac #(
        .IMAGE_PIXEL_WIDTH  (8),
        .KERNEL_PIXEL_WIDTH (8),
        .KERNEL_SIZE        (3),
        .OUT_WIDTH          (8),
        .NUM_WINDOWS        (4),
        .RELU_EN            (1)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .IMD       (IMD),
        .wgt_load  (wgt_load),
        .WC1D      (WC1D),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .map_done  (map_done),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: dot product as plain integers, then clamp into 0..255.
    function automatic logic [7:0] model(input vec9_t p, input vec9_t w);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            s += int'(p[i]) * int'($signed(w[i]));
        end
        if (s < 0) return 8'd0;
        else if (s > 255) return 8'd255;
        else return 8'(s);
    endfunction

    function automatic vec9_t rand_vec();
        vec9_t v;
        for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic vec9_t fill_vec(input logic [7:0] x);
        vec9_t v;
        for (int i = 0; i < 9; i++) v[i] = x;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_w(input vec9_t w);
        WC1D     = w;
        wgt_load = 1'b1;
        @(negedge clock);
        wgt_load = 1'b0;
        cur_w    = w;
    endtask

    // Present one window; optionally glitch win_valid or reload weights k cycles after acceptance.
    task automatic run_window(input string tag, input vec9_t pix, input int ovr_at,
                              input int wl_at, input vec9_t new_w);
        vec9_t      eff_w;
        logic [7:0] exp;
        int         lat;
        check({tag, "_ready"}, 32'(win_ready), 32'd1);
        IMD       = pix;
        win_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        win_valid = 1'b0;
        eff_w = cur_w;
        lat   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            win_valid = 1'b0;
            wgt_load  = 1'b0;
            if (k == 1) check({tag, "_busy"}, 32'(win_ready), 32'd0);
            if (pix_valid) begin
                lat = k;
                break;
            end
            if (k == ovr_at) begin
                IMD       = rand_vec();
                win_valid = 1'b1;
            end
            if (k == wl_at) begin
                WC1D     = new_w;
                wgt_load = 1'b1;
                for (int i = 0; i < 9; i++) if (i > k) eff_w[i] = new_w[i];
                cur_w = new_w;
            end
        end
        win_valid = 1'b0;
        wgt_load  = 1'b0;
        exp = model(pix, eff_w);
        n_win++;
        if (ovr_at > 0) exp_ovr = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check({tag, "_pix_out"}, 32'(pix_out), 32'(exp));
        check({tag, "_map_done"}, 32'(map_done), 32'(n_win >= 4));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        @(negedge clock);
        check({tag, "_pulse_width"}, 32'(pix_valid), 32'd0);
        check({tag, "_hold"}, 32'(pix_out), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec9_t      lap;
        vec9_t      ramp;
        vec9_t      pix;
        vec9_t      w;
        logic [7:0] expq[$];
        int         sent;
        int         got;
        int         last_t;
        int         seen;

        chk_n = 0; err_n = 0; n_win = 0; exp_ovr = 1'b0;
        cur_w = '0;
        rst_n = 1'b0; win_valid = 1'b0; wgt_load = 1'b0; IMD = '0; WC1D = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(win_ready), 32'd1);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_map_done", 32'(map_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);

        // Laplacian over a flat window sums to zero.
        lap = '0;
        lap[1] = 8'd1; lap[3] = 8'd1; lap[4] = 8'hFC; lap[5] = 8'd1; lap[7] = 8'd1;
        load_w(lap);
        run_window("laplace", fill_vec(8'd10), 0, 0, '0);

        for (int i = 0; i < 9; i++) ramp[i] = 8'(i);
        load_w(fill_vec(8'd1));
        run_window("ramp_pos", ramp, 0, 0, '0);
        check("ramp_pos_value", 32'(pix_out), 32'd36);
        load_w(fill_vec(8'hFF));
        run_window("ramp_neg", ramp, 0, 0, '0);
        load_w(fill_vec(8'd127));
        run_window("saturate", fill_vec(8'd255), 0, 0, '0);
        check("saturate_value", 32'(pix_out), 32'd255);

        // Four back-to-back windows; first one loads new weights in the same cycle.
        w = rand_vec();
        sent = 0; got = 0; last_t = 0;
        for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
            win_valid = 1'b0;
            wgt_load  = 1'b0;
            if (pix_valid) begin
                if (expq.size() > 0) check("stream_pix_out", 32'(pix_out), 32'(expq.pop_front()));
                else check("stream_extra_pulse", 32'd1, 32'd0);
                if (got > 0) check("stream_spacing", 32'(cyc - last_t), 32'd11);
                last_t = cyc;
                got++;
                check("stream_map_done", 32'(map_done), 32'd1);
            end
            if (win_ready && sent < 4) begin
                pix = rand_vec();
                IMD = pix;
                win_valid = 1'b1;
                if (sent == 0) begin
                    WC1D = w; wgt_load = 1'b1; cur_w = w;
                end
                expq.push_back(model(pix, cur_w));
                sent++;
            end
            @(negedge clock);
        end
        win_valid = 1'b0;
        wgt_load  = 1'b0;
        n_win += 4;
        check("stream_count", 32'(got), 32'd4);
        check("stream_overrun", 32'(overrun), 32'd0);

        run_window("overrun", rand_vec(), 2, 0, '0);
        run_window("midload", rand_vec(), 0, 3, rand_vec());

        // Reset while accumulating element 4.
        IMD = rand_vec();
        win_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        win_valid = 1'b0;
        repeat (4) @(negedge clock);
        #1 rst_n = 1'b0;
        #1;
        n_win = 0; exp_ovr = 1'b0; cur_w = '0;
        check("midrst_ready", 32'(win_ready), 32'd1);
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        check("midrst_pix_out", 32'(pix_out), 32'd0);
        check("midrst_map_done", 32'(map_done), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (pix_valid) seen++;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);

        // Weights were cleared by reset.
        run_window("zero_w", rand_vec(), 0, 0, '0);

        for (int t = 0; t < 6; t++) begin
            load_w(rand_vec());
            run_window("random", rand_vec(), 0, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameter IMAGE_PIXEL_WIDTH, 8, unsigned image pixel width.
REQ-002 SHALL have parameter KERNEL_PIXEL_WIDTH, 8, two's-complement kernel weight width.
REQ-003 SHALL have parameter KERNEL_SIZE, 3, kernel side length; window holds KERNEL_SIZE*KERNEL_SIZE (N) elements.
REQ-004 SHALL have parameter OUT_WIDTH, 8, unsigned output pixel width.
REQ-005 SHALL have parameter NUM_WINDOWS, 576, number of windows per feature map.
REQ-006 SHALL have parameter RELU_EN, 1; 1 clamps negative sums to 0.
REQ-007 Ports: clock  in  1  single clock; all state is updated on its rising edge.
REQ-008 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-009 Ports: win_valid  in  1  IMD window stable this cycle.
REQ-010 Ports: win_ready  out  1  block idle, can accept a window.
REQ-011 Ports: IMD  in  [IMAGE_PIXEL_WIDTH-1:0] x N  image window, row-major.
REQ-012 Ports: wgt_load  in  1  capture weights this cycle.
REQ-013 Ports: WC1D  in  [KERNEL_PIXEL_WIDTH-1:0] x N  kernel weights, row-major.
REQ-014 Ports: pix_out  out  OUT_WIDTH  result pixel.
REQ-015 Ports: pix_valid  out  1  one-cycle pulse, pix_out valid.
REQ-016 Ports: map_done  out  1  sticky, all NUM_WINDOWS results emitted.
REQ-017 Ports: overrun  out  1  sticky, win_valid seen while win_ready low.

Function
REQ-018 FSM states IDLE, ACCUM, EMIT; reset state IDLE.
REQ-019 IDLE: win_ready=1; win_valid=1 -> capture all N IMD elements into an internal window register, clear accumulator and element index, go ACCUM.
REQ-020 ACCUM: one product per cycle, acc += $signed({1'b0,pixel[idx]}) * $signed(weight[idx]), idx 0..N-1; after idx=N-1 go EMIT.
REQ-021 Accumulator width SHALL be IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH+1+$clog2(N); no internal overflow.
REQ-022 EMIT: pix_valid=1 for exactly one cycle, pix_out = post-processed acc, window counter += 1, go IDLE.
REQ-023 Post-processing: RELU_EN=1 and acc<0 -> 0; RELU_EN=0 and acc<0 -> 0 as well (unsigned output); acc > 2^OUT_WIDTH-1 -> 2^OUT_WIDTH-1; else acc[OUT_WIDTH-1:0].
REQ-024 Latency: win_valid accepted at edge T -> pix_valid high in cycle T+N+1; throughput one window per N+2 cycles.
REQ-025 win_valid while win_ready=0 SHALL be ignored (window not captured) and SHALL set overrun.
REQ-026 wgt_load SHALL capture all N WC1D values in any state; during ACCUM the new weights apply from the next product onward; wgt_load and win_valid in the same cycle -> window uses the new weights.
REQ-027 Window counter wraps to 0 after NUM_WINDOWS-1; map_done set in the EMIT of window NUM_WINDOWS-1, held until reset; processing continues after map_done.
REQ-028 pix_out SHALL hold its last value between pix_valid pulses.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, win_ready=1, pix_valid=0, pix_out=0, map_done=0, overrun=0, counter=0, accumulator=0, weights=0.
REQ-030 Reset asserted mid-ACCUM SHALL discard the partial sum; no pix_valid follows.

Structure
REQ-031 Shared package conv_pkg SHALL hold the FSM state enum and the accumulator-width constant function.
REQ-032 Saturation/ReLU SHALL be one sub-module conv_sat_relu (combinational, parameterised on accumulator and output width).

Verification (KERNEL_SIZE=3, OUT_WIDTH=8, NUM_WINDOWS=4)
REQ-033 Window all 10, weights {0,1,0,1,-4,1,0,1,0} -> pix_out=0, pix_valid exactly 10 cycles after acceptance.
REQ-034 Window 0..8, weights all 1 -> pix_out=36; window 0..8, weights all -1 -> pix_out=0.
REQ-035 Window all 255, weights all 127 (sum 291465) -> pix_out=255.
REQ-036 Four back-to-back windows -> four pix_valid pulses 11 cycles apart; map_done rises with fourth pulse and stays high.
REQ-037 win_valid pulsed during ACCUM -> overrun=1, result unchanged; rst_n low at ACCUM idx 4 -> no pix_valid, all outputs at reset values.
